// File: rtl/seg7_pattern_decoder_pkg.sv
// seg7_pattern_decoder_pkg
//   Shared definitions for the 7-segment read-back path.
//   - SEG_0..SEG_F, SEG_BLANK: segment patterns in gfedcba order.
//     Bit 0 is segment a and bit 6 is segment g.
//   - state_t: settle FSM states (ST_WAIT, ST_SETTLE).
//   - seg7_encode: forward hex-to-segment encoder. seg7_pattern_lut inverts it.
package seg7_pattern_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = SEG_A;
      4'hB:    pat = SEG_B;
      4'hC:    pat = SEG_C;
      4'hD:    pat = SEG_D;
      4'hE:    pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_lut.sv
// seg7_pattern_lut
//   Combinational inverse of seg7_encode. It maps a 7-bit segment pattern
//   back to its hex code.
//   Ports:
//     pattern_i [6:0] : segment pattern in gfedcba order
//     hit_o           : 1 when the pattern is one of the 16 hex glyphs
//     code_o    [3:0] : decoded hex value, 0 when hit_o is 0
module seg7_pattern_lut
  import seg7_pattern_decoder_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic       hit_o,
  output logic [3:0] code_o
);

  always_comb begin
    hit_o  = 1'b1;
    code_o = 4'h0;
    case (pattern_i)
      SEG_0:   code_o = 4'h0;
      SEG_1:   code_o = 4'h1;
      SEG_2:   code_o = 4'h2;
      SEG_3:   code_o = 4'h3;
      SEG_4:   code_o = 4'h4;
      SEG_5:   code_o = 4'h5;
      SEG_6:   code_o = 4'h6;
      SEG_7:   code_o = 4'h7;
      SEG_8:   code_o = 4'h8;
      SEG_9:   code_o = 4'h9;
      SEG_A:   code_o = 4'hA;
      SEG_B:   code_o = 4'hB;
      SEG_C:   code_o = 4'hC;
      SEG_D:   code_o = 4'hD;
      SEG_E:   code_o = 4'hE;
      SEG_F:   code_o = 4'hF;
      default: hit_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder
//   Reads back a multiplexed two-digit 7-segment display. The bus is
//   synchronised first. A pattern is accepted only after it has been stable
//   for STABLE_CYCLES samples. The accepted pattern is then decoded to hex
//   and placed in the tens or ones nibble that digit_sel selects. Illegal
//   patterns are flagged and counted.
//   Ports:
//     C              : clock; all logic runs on the rising edge
//     CLR            : synchronous active-high reset; overrides CE
//     CE             : clock enable; when 0, all state holds and no pulses occur
//     seg_in   [7:0] : segment bus Dgfedcba, asynchronous to C
//     digit_sel      : 0 = ones digit on bus, 1 = tens digit
//     value    [3:0] : last decoded hex value
//     dp             : decimal point of last accepted pattern
//     valid          : one-cycle pulse when a legal glyph is accepted
//     err            : one-cycle pulse when an illegal, non-blank pattern is accepted
//     blank          : level; last accepted pattern had all segments off
//     bcd_value[7:0] : {tens, ones} assembled from accepted digits
//     err_count[7:0] : saturating count of err pulses
//     dbg_state      : 1 while the FSM is in ST_SETTLE
//   Handshake: valid and err are pulses with no ready. Each is high for
//   exactly one cycle per accepted pattern. They are never high together.
module seg7_pattern_decoder
  import seg7_pattern_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       C,
  input  logic       CLR,
  input  logic       CE,
  input  logic [7:0] seg_in,
  input  logic       digit_sel,
  output logic [3:0] value,
  output logic       dp,
  output logic       valid,
  output logic       err,
  output logic       blank,
  output logic [7:0] bcd_value,
  output logic [7:0] err_count,
  output logic       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [8:0]       sync1_q, sync2_q;
  logic [8:0]       prev_q;
  logic [CNT_W-1:0] cnt_q;
  state_t           state_q;
  logic [3:0]       value_q;
  logic             dp_q, valid_q, err_q, blank_q;
  logic [7:0]       bcd_q, err_count_q;

  logic             lut_hit;
  logic [3:0]       lut_code;

  // The LUT always decodes the candidate pattern. Its result is used only
  // on the accept cycle.
  seg7_pattern_lut u_lut (
    .pattern_i (prev_q[6:0]),
    .hit_o     (lut_hit),
    .code_o    (lut_code)
  );

  always_ff @(posedge C) begin
    if (CLR) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_WAIT;
      value_q     <= 4'h0;
      dp_q        <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      blank_q     <= 1'b1;
      bcd_q       <= 8'h00;
      err_count_q <= 8'h00;
    end else if (CE) begin
      sync1_q <= {digit_sel, seg_in};
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          // prev_q still holds the last accepted pattern. An unchanged bus
          // is therefore never re-accepted.
          if (sync2_q != prev_q) begin
            prev_q  <= sync2_q;
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (sync2_q != prev_q) begin
            // Glitch: restart settling on the new candidate.
            prev_q <= sync2_q;
            cnt_q  <= '0;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            state_q <= ST_WAIT;
            dp_q    <= prev_q[7];
            if (lut_hit) begin
              value_q <= lut_code;
              valid_q <= 1'b1;
              blank_q <= 1'b0;
              if (prev_q[8]) bcd_q[7:4] <= lut_code;
              else           bcd_q[3:0] <= lut_code;
            end else if (prev_q[6:0] == SEG_BLANK) begin
              blank_q <= 1'b1;
            end else begin
              err_q   <= 1'b1;
              blank_q <= 1'b0;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
          end
        end
        default: state_q <= ST_WAIT;
      endcase
    end else begin
      // Frozen: the pulses must not stretch across stalled cycles.
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  assign value     = value_q;
  assign dp        = dp_q;
  assign valid     = valid_q;
  assign err       = err_q;
  assign blank     = blank_q;
  assign bcd_value = bcd_q;
  assign err_count = err_count_q;
  assign dbg_state = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
module tb_seg7_pattern_decoder;

  localparam int STABLE = 4;

  // ---------------- clock / reset ----------------
  logic       C = 1'b0;
  logic       CLR = 1'b0;
  logic       CE = 1'b1;
  logic [7:0] seg_in = 8'h00;
  logic       digit_sel = 1'b0;

  logic [3:0] value;
  logic       dp, valid, err, blank, dbg_state;
  logic [7:0] bcd_value, err_count;

  int total = 0;
  int bad   = 0;

  always #5 C = ~C;

  seg7_pattern_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
    .C         (C),
    .CLR       (CLR),
    .CE        (CE),
    .seg_in    (seg_in),
    .digit_sel (digit_sel),
    .value     (value),
    .dp        (dp),
    .valid     (valid),
    .err       (err),
    .blank     (blank),
    .bcd_value (bcd_value),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Glyph table indexed by hex value.
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // The model sees the bus two enabled samples late. It accepts a run of
  // identical samples once that run reaches STABLE+1 samples. A run is
  // accepted at most once.
  logic [8:0] m_pipe [2];
  logic [8:0] m_run_val;
  int         m_run_len;
  bit         m_run_done;
  logic [3:0] m_value;
  logic       m_dp, m_valid, m_err, m_blank;
  logic [7:0] m_bcd, m_errcnt;

  // scoreboard of expected pulses: {valid, err, value}
  logic [5:0] exp_q [$];

  function automatic void model_accept(input logic [8:0] p);
    int idx;
    idx  = -1;
    for (int i = 0; i < 16; i++) if (seg_tbl[i] == p[6:0]) idx = i;
    m_dp = p[7];
    if (idx >= 0) begin
      m_value = 4'(idx);
      m_valid = 1'b1;
      m_blank = 1'b0;
      if (p[8]) m_bcd = {4'(idx), m_bcd[3:0]};
      else      m_bcd = {m_bcd[7:4], 4'(idx)};
    end else if (p[6:0] == 7'h00) begin
      m_blank = 1'b1;
    end else begin
      m_err   = 1'b1;
      m_blank = 1'b0;
      if (m_errcnt < 8'd255) m_errcnt = m_errcnt + 8'd1;
    end
    if (m_valid || m_err) exp_q.push_back({m_valid, m_err, m_value});
  endfunction

  function automatic void model_step();
    if (CLR) begin
      m_pipe[0] = '0; m_pipe[1] = '0;
      m_run_val = '0; m_run_len = 0; m_run_done = 1'b1;
      m_value = 4'h0; m_dp = 1'b0; m_valid = 1'b0; m_err = 1'b0;
      m_blank = 1'b1; m_bcd = 8'h00; m_errcnt = 8'h00;
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (CE) begin
        if (m_pipe[1] != m_run_val) begin
          m_run_val  = m_pipe[1];
          m_run_len  = 1;
          m_run_done = 1'b0;
        end else if (!m_run_done) begin
          m_run_len++;
        end
        if (!m_run_done && m_run_len == STABLE + 1) begin
          m_run_done = 1'b1;
          model_accept(m_run_val);
        end
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = {digit_sel, seg_in};
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge C);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    CLR = 1'b1; CE = 1'b1; seg_in = 8'h00; digit_sel = 1'b0;
    tick(); tick();
    CLR = 1'b0;
    total++; if (value !== 4'h0) begin bad++; $display("FAIL reset_value: got %h want 0", value); end
    total++; if (bcd_value !== 8'h00) begin bad++; $display("FAIL reset_bcd: got %h want 00", bcd_value); end
    total++; if (err_count !== 8'h00) begin bad++; $display("FAIL reset_errcnt: got %h want 00", err_count); end
    total++; if ({blank, valid, err, dp} !== 4'b1000) begin bad++; $display("FAIL reset_flags: got blank/valid/err/dp=%b want 1000", {blank, valid, err, dp}); end
    total++; if (dbg_state !== 1'b0) begin bad++; $display("FAIL reset_state: got %b want 0", dbg_state); end
  endtask

  task automatic test_single_digit();
    int first = 0;
    int nv = 0;
    digit_sel = 1'b0; seg_in = 8'h4F;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (valid) begin nv++; if (first == 0) first = i; end
    end
    total++; if (first != 1 + 2 + STABLE) begin bad++; $display("FAIL single_latency: got edge %0d want %0d", first, 1 + 2 + STABLE); end
    total++; if (nv != 1) begin bad++; $display("FAIL single_pulses: got %0d want 1", nv); end
    total++; if (value !== 4'h3) begin bad++; $display("FAIL single_value: got %h want 3", value); end
    total++; if (bcd_value !== 8'h03) begin bad++; $display("FAIL single_bcd: got %h want 03", bcd_value); end
    total++; if (dp !== 1'b0) begin bad++; $display("FAIL single_dp: got %b want 0", dp); end
  endtask

  task automatic test_tens_dp();
    int nv = 0;
    digit_sel = 1'b1; seg_in = 8'hED;
    for (int i = 0; i < 10; i++) begin tick(); if (valid) nv++; end
    total++; if (nv != 1) begin bad++; $display("FAIL tens_pulses: got %0d want 1", nv); end
    total++; if (value !== 4'h5) begin bad++; $display("FAIL tens_value: got %h want 5", value); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL tens_dp: got %b want 1", dp); end
    total++; if (bcd_value !== 8'h53) begin bad++; $display("FAIL tens_bcd: got %h want 53", bcd_value); end
  endtask

  task automatic test_glitch();
    int np = 0;
    digit_sel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seg_in = ((i / 2) % 2 == 1) ? 8'h5B : 8'h06;
      tick();
      if (valid || err) np++;
    end
    total++; if (np != 0) begin bad++; $display("FAIL glitch_quiet: got %0d pulses want 0", np); end
    np = 0;
    seg_in = 8'h5B;
    for (int i = 0; i < 12; i++) begin tick(); if (valid) np++; end
    total++; if (np != 1) begin bad++; $display("FAIL glitch_settle: got %0d pulses want 1", np); end
    total++; if (value !== 4'h2) begin bad++; $display("FAIL glitch_value: got %h want 2", value); end
    total++; if (bcd_value !== 8'h52) begin bad++; $display("FAIL glitch_bcd: got %h want 52", bcd_value); end
  endtask

  task automatic test_errors();
    int ne = 0;
    digit_sel = 1'b0;
    seg_in = 8'h12;
    for (int i = 0; i < 9; i++) begin tick(); if (err) ne++; end
    seg_in = 8'h00;
    for (int i = 0; i < 9; i++) begin tick(); if (err) ne++; end
    total++; if (blank !== 1'b1) begin bad++; $display("FAIL err_blank_between: got %b want 1", blank); end
    seg_in = 8'h12;
    for (int i = 0; i < 9; i++) begin tick(); if (err) ne++; end
    total++; if (ne != 2) begin bad++; $display("FAIL err_pulses: got %0d want 2", ne); end
    total++; if (err_count !== 8'h02) begin bad++; $display("FAIL err_count2: got %h want 02", err_count); end
    total++; if (value !== 4'h2) begin bad++; $display("FAIL err_value_hold: got %h want 2", value); end
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL err_blank_clear: got %b want 0", blank); end
    ne = 0;
    for (int n = 0; n < 300; n++) begin
      seg_in = (n % 2 == 0) ? 8'h13 : 8'h12;
      for (int i = 0; i < 8; i++) begin tick(); if (err) ne++; end
    end
    total++; if (ne != 300) begin bad++; $display("FAIL err_many_pulses: got %0d want 300", ne); end
    total++; if (err_count !== 8'hFF) begin bad++; $display("FAIL err_saturate: got %h want ff", err_count); end
  endtask

  task automatic test_ce_stall();
    int first = 0;
    digit_sel = 1'b0; seg_in = 8'h06;
    for (int i = 1; i <= 20; i++) begin
      CE = (i >= 4 && i <= 8) ? 1'b0 : 1'b1;
      tick();
      if (valid && first == 0) first = i;
    end
    CE = 1'b1;
    total++; if (first != 1 + 2 + STABLE + 5) begin bad++; $display("FAIL ce_latency: got edge %0d want %0d", first, 1 + 2 + STABLE + 5); end
    total++; if (value !== 4'h1) begin bad++; $display("FAIL ce_value: got %h want 1", value); end
  endtask

  task automatic test_clr_abort();
    int np = 0;
    digit_sel = 1'b0; seg_in = 8'h66;
    for (int i = 0; i < 4; i++) begin tick(); if (valid || err) np++; end
    total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL clr_mid_settle_state: got %b want 1", dbg_state); end
    CLR = 1'b1; seg_in = 8'h00;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (valid || err) np++; end
    total++; if (np != 0) begin bad++; $display("FAIL clr_abort_pulses: got %0d want 0", np); end
    total++; if ({value, bcd_value, err_count, blank} !== {4'h0, 8'h00, 8'h00, 1'b1}) begin
      bad++; $display("FAIL clr_abort_state: got v=%h bcd=%h ec=%h bl=%b want 0 00 00 1", value, bcd_value, err_count, blank);
    end
  endtask

  task automatic test_random();
    logic [5:0]  e;
    logic [23:0] got, want;
    int          hold;
    CLR = 1'b1; CE = 1'b1; tick(); CLR = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: seg_in = {1'($urandom_range(0, 1)), seg_tbl[$urandom_range(0, 15)]};
        3:       seg_in = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 127))};
        default: seg_in = {1'($urandom_range(0, 1)), 7'h00};
      endcase
      digit_sel = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 9);
      for (int i = 0; i < hold; i++) begin
        CE = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
        tick();
        got  = {value, dp, valid, err, blank, bcd_value, err_count};
        want = {m_value, m_dp, m_valid, m_err, m_blank, m_bcd, m_errcnt};
        total++; if (got !== want) begin bad++; $display("FAIL rand_outputs: got %h want %h", got, want); end
        if (valid || err) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL rand_pulse_unexpected: got v=%b e=%b want no pulse", valid, err);
          end else begin
            e = exp_q.pop_front();
            if ({valid, err, value} !== e) begin bad++; $display("FAIL rand_pulse: got %h want %h", {valid, err, value}, e); end
          end
        end
      end
    end
    CE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid || err) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_tail_unexpected: got v=%b e=%b want no pulse", valid, err);
        end else begin
          e = exp_q.pop_front();
          if ({valid, err, value} !== e) begin bad++; $display("FAIL rand_tail_pulse: got %h want %h", {valid, err, value}, e); end
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_missing_pulses: got %0d left want 0", exp_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_digit();
    test_tens_dp();
    test_glitch();
    test_errors();
    test_ce_stall();
    test_clr_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
